// File: rtl/fa_pkg.sv
// Shared definitions for the full-adder / full-subtractor group:
// FSM state encoding and the bit-counter width helper.
package fa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit counter only needs to reach WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/fs_1bit.sv
// Combinational one-bit full subtractor: dif = x - y - bi, bo = borrow out.
module fs_1bit (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic dif,
  output logic bo
);

  assign dif = x ^ y ^ bi;
  assign bo  = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/fs_serial_nbit.sv
// Bit-serial WIDTH-bit subtractor: d = a - b - Bin, one bit per clock, LSB
// first, through a single fs_1bit cell.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Input side: in_ready is high only in IDLE; a, b, Bin are
// captured on the accepting edge. Output side: out_valid is high only in
// DONE; d/Bout/ovf/zero are stable while out_valid=1 and out_ready=0, and
// keep their value after the transfer until the next result is loaded.
module fs_serial_nbit
  import fa_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] d,
  output logic             Bout,
  output logic             ovf,
  output logic             zero,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic               brw_q, brw_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  // Bits already produced; the newest bit enters at the top.
  logic [WIDTH-2:0]   r_q, r_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic               bout_q, bout_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;

  logic               cell_dif, cell_bo;
  logic [WIDTH-1:0]   res_shift;

  fs_1bit u_cell (
    .x   (a_sh_q[0]),
    .y   (b_sh_q[0]),
    .bi  (brw_q),
    .dif (cell_dif),
    .bo  (cell_bo)
  );

  // Partial result after this edge's bit is shifted in; complete on the last bit.
  assign res_shift = {cell_dif, r_q};

  // Next-state and datapath update; everything holds unless a case changes it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    brw_d   = brw_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    r_d     = r_q;
    d_d     = d_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          brw_d   = Bin;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        brw_d  = cell_bo;
        r_d    = res_shift[WIDTH-1:1];
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
          d_d     = res_shift;
          bout_d  = cell_bo;
          ovf_d   = (a_msb_q != b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
          zero_d  = (res_shift == '0);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      brw_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      r_q     <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      brw_q   <= brw_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      r_q     <= r_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign d         = d_q;
  assign Bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_fs_serial_nbit.sv
// Bench for fs_serial_nbit: one WIDTH=4 and one WIDTH=16 instance sharing
// clock and reset; a select bit steers stimulus and observation.
module tb_fs_serial_nbit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus / observation ----------------
  bit          sel = 1'b0;   // 0: WIDTH=4 instance, 1: WIDTH=16 instance
  logic [15:0] a_in = '0, b_in = '0;
  logic        bin_in = 1'b0, iv = 1'b0, ordy = 1'b0;

  logic [3:0]  d4;
  logic        in_ready4, bout4, ovf4, zero4, out_valid4;
  logic [15:0] d16;
  logic        in_ready16, bout16, ovf16, zero16, out_valid16;

  logic [15:0] obs_d;
  logic        obs_in_ready, obs_bout, obs_ovf, obs_zero, obs_out_valid;

  assign obs_d         = sel ? d16 : {12'd0, d4};
  assign obs_in_ready  = sel ? in_ready16 : in_ready4;
  assign obs_bout      = sel ? bout16 : bout4;
  assign obs_ovf       = sel ? ovf16 : ovf4;
  assign obs_zero      = sel ? zero16 : zero4;
  assign obs_out_valid = sel ? out_valid16 : out_valid4;

  fs_serial_nbit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .a(a_in[3:0]), .b(b_in[3:0]), .Bin(bin_in),
    .in_valid(iv && !sel), .in_ready(in_ready4), .d(d4), .Bout(bout4),
    .ovf(ovf4), .zero(zero4), .out_valid(out_valid4), .out_ready(ordy && !sel)
  );

  fs_serial_nbit #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .a(a_in), .b(b_in), .Bin(bin_in),
    .in_valid(iv && sel), .in_ready(in_ready16), .d(d16), .Bout(bout16),
    .ovf(ovf16), .zero(zero16), .out_valid(out_valid16), .out_ready(ordy && sel)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction, flags from the arithmetic rules.
  function automatic void ref_sub(input int w, input logic [15:0] a, input logic [15:0] b,
                                  input logic bin, output logic [15:0] d,
                                  output logic bout, output logic ovf, output logic zero);
    longint m, av, bv, diff, dv;
    bit sa, sb, sd;
    m    = longint'(1) << w;
    av   = longint'(a) % m;
    bv   = longint'(b) % m;
    diff = av - bv - longint'(bin);
    bout = (diff < 0);
    dv   = (diff + m) % m;
    d    = 16'(dv);
    sa   = (av >= m / 2);
    sb   = (bv >= m / 2);
    sd   = (dv >= m / 2);
    ovf  = (sa != sb) && (sd != sa);
    zero = (dv == 0);
  endfunction

  // ---------------- driver ----------------
  // One complete operation on the selected instance. hold = cycles of
  // out_ready=0 in DONE (random when rnd is set).
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                       input bit rnd, input int hold);
    int w, n, k;
    logic [15:0] ed;
    logic eb, eo, ez;
    w = sel ? 16 : 4;
    ref_sub(w, a, b, bin, ed, eb, eo, ez);
    exp_q.push_back(ed);
    if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
    n = 0;
    while (!obs_in_ready && n < 50) begin @(negedge clk); n++; end
    chk("in_ready_before_accept", obs_in_ready, 1);
    a_in = a; b_in = b; bin_in = bin; iv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv = 1'b0; a_in = 16'($urandom); b_in = 16'($urandom); bin_in = 1'($urandom);
    chk("in_ready_in_shift", obs_in_ready, 0);
    n = 0;
    while (!obs_out_valid && n < 40) begin @(posedge clk); @(negedge clk); n++; end
    chk("latency_edges", n, w);
    chk("d", obs_d, exp_q.pop_front());
    chk("bout", obs_bout, eb);
    chk("ovf", obs_ovf, eo);
    chk("zero", obs_zero, ez);
    chk("in_ready_in_done", obs_in_ready, 0);
    k = rnd ? int'($urandom_range(0, 3)) : hold;
    for (int i = 0; i < k; i++) begin
      a_in = ~a_in; b_in = ~b_in; bin_in = ~bin_in; iv = ~iv;
      @(posedge clk);
      @(negedge clk);
      chk("hold_out_valid", obs_out_valid, 1);
      chk("hold_in_ready", obs_in_ready, 0);
      chk("hold_d", obs_d, ed);
      chk("hold_flags", {obs_bout, obs_ovf, obs_zero}, {eb, eo, ez});
    end
    iv = 1'b0;
    ordy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy = 1'b0;
    chk("out_valid_after_accept", obs_out_valid, 0);
    chk("in_ready_after_accept", obs_in_ready, 1);
    chk("d_kept_after_accept", obs_d, ed);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    #1;
    chk("rst_in_ready", obs_in_ready, 1);
    chk("rst_out_valid", obs_out_valid, 0);
    chk("rst_outputs", {obs_d, obs_bout, obs_ovf, obs_zero}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    sel = 1'b0;
    do_op(16'd9, 16'd3, 1'b0, 1'b0, 0);
    do_op(16'd3, 16'd9, 1'b0, 1'b0, 0);
    do_op(16'd8, 16'd1, 1'b0, 1'b0, 0);
    do_op(16'd5, 16'd4, 1'b1, 1'b0, 0);
    do_op(16'd0, 16'd15, 1'b1, 1'b0, 0);
    // Backpressure: five stalled cycles in DONE, accept on the sixth.
    do_op(16'd9, 16'd3, 1'b0, 1'b0, 5);

    // Reset two edges into SHIFT.
    while (!obs_in_ready) @(negedge clk);
    a_in = 16'd12; b_in = 16'd1; bin_in = 1'b0; iv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", obs_out_valid, 0);
    chk("midrst_d", obs_d, 0);
    chk("midrst_flags", {obs_bout, obs_ovf, obs_zero}, 0);
    chk("midrst_in_ready", obs_in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_in_ready", obs_in_ready, 1);
    chk("postrst_out_valid", obs_out_valid, 0);
    do_op(16'd7, 16'd2, 1'b0, 1'b0, 0);

    // Exhaustive WIDTH=4 sweep with random stalls.
    for (int x = 0; x < 512; x++)
      do_op(16'(x & 15), 16'((x >> 4) & 15), 1'(x >> 8), 1'b1, 0);

    // WIDTH=16: corners then random samples.
    sel = 1'b1;
    @(negedge clk);
    do_op(16'h0000, 16'hFFFF, 1'b1, 1'b0, 0);
    do_op(16'h8000, 16'h0001, 1'b0, 1'b0, 0);
    do_op(16'h7FFF, 16'hFFFF, 1'b0, 1'b0, 2);
    for (int i = 0; i < 1000; i++)
      do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
